// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin arbitration in front of a single
// SETUP/ACCESS bus engine with pready timeout and illegal-select rejection.
module apb_master_arbiter #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  pclk,
  input  logic                  Reset,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_write,
  input  logic [3:0]            req_sel,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            req_grant,
  output logic [1:0]            req_done,
  output logic [1:0]            req_err,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_W-1:0]     paddr,
  output logic [DATA_W-1:0]     pwdata,
  input  logic [DATA_W-1:0]     prdata,
  input  logic                  pready
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic                idx_q, idx_d;
  logic                legal_q, legal_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          grant_q, grant_d;
  logic [1:0]          done_q, done_d;
  logic [1:0]          err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;

  logic                win_c;
  logic [1:0]          win_sel_c;
  logic                timeout_c;

  // Round-robin pick: on contention the requester not granted last wins.
  always_comb begin
    if (req_valid == 2'b11) begin
      win_c = ~last_q;
    end else begin
      win_c = req_valid[1];
    end
    win_sel_c = win_c ? req_sel[3:2] : req_sel[1:0];
  end

  assign timeout_c = (cnt_q == CNT_MAX);

  // State register
  always_ff @(posedge pclk) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid != 2'b00) state_d = SETUP;
      SETUP:   state_d = legal_q ? ACCESS : IDLE;
      ACCESS:  if (pready || timeout_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values; pulses default low, everything else holds.
  always_comb begin
    last_d    = last_q;
    idx_d     = idx_q;
    legal_d   = legal_q;
    cnt_d     = cnt_q;
    grant_d   = 2'b00;
    done_d    = 2'b00;
    err_d     = 2'b00;
    rdata_d   = rdata_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid != 2'b00) begin
          grant_d[win_c] = 1'b1;
          last_d         = win_c;
          idx_d          = win_c;
          legal_d        = (win_sel_c == 2'b01) || (win_sel_c == 2'b10);
          psel_d         = legal_d ? win_sel_c : 2'b00;
          penable_d      = 1'b0;
          pwrite_d       = req_write[win_c];
          paddr_d        = win_c ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
          pwdata_d       = win_c ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
          cnt_d          = '0;
        end
      end
      SETUP: begin
        cnt_d = '0;
        if (!legal_q) begin
          done_d[idx_q] = 1'b1;
          err_d[idx_q]  = 1'b1;
        end else begin
          penable_d = 1'b1;
        end
      end
      ACCESS: begin
        // pready on the final counted cycle still wins over the timeout.
        if (pready) begin
          done_d[idx_q] = 1'b1;
          psel_d        = 2'b00;
          penable_d     = 1'b0;
          if (!pwrite_q) rdata_d = prdata;
        end else if (timeout_c) begin
          done_d[idx_q] = 1'b1;
          err_d[idx_q]  = 1'b1;
          psel_d        = 2'b00;
          penable_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        psel_d    = 2'b00;
        penable_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge pclk) begin
    if (Reset) begin
      last_q    <= 1'b1;
      idx_q     <= 1'b0;
      legal_q   <= 1'b0;
      cnt_q     <= '0;
      grant_q   <= 2'b00;
      done_q    <= 2'b00;
      err_q     <= 2'b00;
      rdata_q   <= '0;
      psel_q    <= 2'b00;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      last_q    <= last_d;
      idx_q     <= idx_d;
      legal_q   <= legal_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign req_grant = grant_q;
  assign req_done  = done_q;
  assign req_err   = err_q;
  assign rdata     = rdata_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;

endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum ACCESS cycles waiting for pready.
REQ-004 SHALL have port pclk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port Reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  input  2  request pending, bit i = requester i.
REQ-007 SHALL have port req_write  input  2  1 = write, 0 = read, per requester.
REQ-008 SHALL have port req_sel  input  4  slave select per requester, [2i+1:2i]; 2'b01 = GPIO, 2'b10 = UART.
REQ-009 SHALL have port req_addr  input  2*ADDR_W  address per requester.
REQ-010 SHALL have port req_wdata  input  2*DATA_W  write data per requester.
REQ-011 SHALL have port req_grant  output  2  one-cycle pulse: request i accepted and latched.
REQ-012 SHALL have port req_done  output  2  one-cycle pulse: transfer i complete.
REQ-013 SHALL have port req_err  output  2  valid with req_done; 1 = timeout or illegal select.
REQ-014 SHALL have port rdata  output  DATA_W  read data, valid with req_done of a read.
REQ-015 SHALL have ports psel  output  2; penable  output  1; pwrite  output  1; paddr  output  ADDR_W; pwdata  output  DATA_W  APB master signals.
REQ-016 SHALL have ports prdata  input  DATA_W; pready  input  1  APB slave response.

Function
REQ-017 SHALL implement FSM states IDLE, SETUP, ACCESS; all outputs registered.
REQ-018 In IDLE with any req_valid set, SHALL grant round-robin: the requester not granted last wins on contention; a sole requester always wins.
REQ-019 On grant SHALL latch write/sel/addr/wdata of the winner, pulse req_grant[i] for one cycle, update last-grant pointer, move to SETUP.
REQ-020 If latched sel is 2'b00 or 2'b11, SHALL skip the bus cycle: pulse req_done[i] and req_err[i] in the cycle after grant, return to IDLE, keep psel = 0.
REQ-021 SETUP SHALL drive psel = sel, penable = 0, pwrite/paddr/pwdata = latched values for exactly one cycle, then go to ACCESS.
REQ-022 ACCESS SHALL hold psel/pwrite/paddr/pwdata stable and drive penable = 1.
REQ-023 In ACCESS with pready = 1, SHALL pulse req_done[i] (req_err = 0) next cycle, capture prdata into rdata on reads, drop psel/penable, return to IDLE.
REQ-024 rdata SHALL hold its last value after writes and errors.
REQ-025 A wait counter SHALL clear on SETUP entry and increment per ACCESS cycle without pready; when it reaches TIMEOUT-1 with pready = 0, SHALL pulse req_done[i] and req_err[i], drop psel/penable, return to IDLE.
REQ-026 pready sampled on the same cycle the counter hits TIMEOUT-1 SHALL count as success, not timeout.
REQ-027 Minimum latency SHALL be grant -> SETUP -> ACCESS -> done: 4 cycles from req_valid to req_done; one IDLE cycle between back-to-back transfers.
REQ-028 req_valid changes after grant SHALL not affect the latched transfer; requester i deasserts req_valid[i] upon req_grant[i].
REQ-029 pready and prdata SHALL be ignored outside ACCESS.

Reset
REQ-030 Reset = 1 at a rising edge SHALL force IDLE, and psel = 0, penable = 0, pwrite = 0, paddr = 0, pwdata = 0, rdata = 0, req_grant = 0, req_done = 0, req_err = 0, wait counter = 0, last-grant pointer = 1 (requester 0 wins first contention).
REQ-031 Reset asserted mid-SETUP or mid-ACCESS SHALL abort the transfer without a req_done pulse.

Verification
REQ-032 Req0 write sel=01 addr=1 wdata=32'hABCD1234, pready=1 in first ACCESS -> grant0, one SETUP cycle psel=01 penable=0, ACCESS penable=1, done0 with err0=0 at cycle 4.
REQ-033 Req1 read sel=01 addr=2, slave returns prdata=32'h00000AAA with pready after 3 wait cycles -> done1, err1=0, rdata=32'h00000AAA.
REQ-034 Both req_valid high continuously after reset, 4 transfers -> grants ordered 0,1,0,1, one IDLE cycle between transfers.
REQ-035 Req0 write sel=10 (UART), pready held 0 -> done0 and err0 after TIMEOUT=16 ACCESS cycles; psel returns to 0.
REQ-036 Req1 sel=11 -> done1 and err1 the cycle after grant, psel never asserted.
REQ-037 Reset asserted in 2nd ACCESS cycle -> all outputs zero next edge, no done pulse; next request after reset completes normally.
